fifo_rr_scheduler: RTL and testbench

//   Shares one FIFO (sync active-high rst, registered dout, write-priority on

---
 rtl/fifo_rr_scheduler.sv | 143 ++++++++++++++
 tb/tb_fifo_rr_scheduler.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_scheduler.sv
// fifo_rr_scheduler: round-robin producer arbitration onto one shared FIFO,
// with read slots interleaved so a valid/ready consumer is never starved.
module fifo_rr_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    req_data,
  output logic [NREQ-1:0]          gnt,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH)-1:0] level,
  output logic                     fifo_rst,
  output logic                     fifo_wr,
  output logic                     fifo_rd,
  output logic [WIDTH-1:0]         fifo_din,
  input  logic [WIDTH-1:0]         fifo_dout,
  input  logic                     fifo_full,
  input  logic                     fifo_empty
);

  localparam int PW = $clog2(NREQ);
  localparam int LW = $clog2(DEPTH);
  localparam logic [PW:0]   NREQ_W = (PW+1)'(NREQ);
  localparam logic [PW-1:0] LAST   = PW'(NREQ-1);
  localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH-1);

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_WRITE,
    OP_READ
  } op_e;

  op_e             op;
  logic            fifo_rst_q;
  logic            out_valid_q, out_valid_d;
  logic            last_wr_q, last_wr_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            rd_want;
  logic            any_req;
  logic            rd_sel;
  logic            wr_sel;
  logic            win_found;
  logic [PW-1:0]   win_idx;
  logic [PW:0]     cand;

  assign rd_want = !fifo_empty && (!out_valid_q || out_ready);
  assign any_req = |req;

  // Read takes the slot after a write, so contending sides alternate.
  assign rd_sel = !fifo_rst_q && rd_want &&
                  (last_wr_q || !any_req || fifo_full);
  assign wr_sel = !fifo_rst_q && !rd_sel &&
                  any_req && !fifo_full;

  always_comb begin
    op = OP_IDLE;
    unique case (1'b1)
      rd_sel:  op = OP_READ;
      wr_sel:  op = OP_WRITE;
      default: op = OP_IDLE;
    endcase
  end

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (cand >= NREQ_W) begin
        cand = cand - NREQ_W;
      end
      if (!win_found && req[cand[PW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    gnt      = '0;
    fifo_din = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (op == OP_WRITE && win_idx == PW'(i)) begin
        gnt[i]   = 1'b1;
        fifo_din = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    out_valid_d = (op == OP_READ) ||
                  (out_valid_q && !out_ready);
    last_wr_d   = (op == OP_WRITE);
    rr_ptr_d    = rr_ptr_q;
    level_d     = level_q;
    unique case (op)
      OP_WRITE: begin
        rr_ptr_d = (win_idx == LAST) ? '0
                                     : win_idx + 1'b1;
        if (level_q != LVL_MAX) begin
          level_d = level_q + 1'b1;
        end
      end
      OP_READ: begin
        if (level_q != '0) begin
          level_d = level_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_rst_q  <= 1'b1;
      out_valid_q <= 1'b0;
      last_wr_q   <= 1'b0;
      rr_ptr_q    <= '0;
      level_q     <= '0;
    end else begin
      fifo_rst_q  <= 1'b0;
      out_valid_q <= out_valid_d;
      last_wr_q   <= last_wr_d;
      rr_ptr_q    <= rr_ptr_d;
      level_q     <= level_d;
    end
  end

  assign fifo_wr   = (op == OP_WRITE);
  assign fifo_rd   = (op == OP_READ);
  assign fifo_rst  = fifo_rst_q;
  assign out_valid = out_valid_q;
  assign out_data  = fifo_dout;
  assign level     = level_q;

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// tb_fifo_rr_scheduler: scheduler plus a behavioural FIFO,
// scoreboard of granted words checked at the consumer port.
module tb_fifo_rr_scheduler;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NREQ-1:0]  req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]  gnt;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [3:0]       level;
  logic             fifo_rst;
  logic             fifo_wr;
  logic             fifo_rd;
  logic [WIDTH-1:0] fifo_din;
  logic [WIDTH-1:0] fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] sb [$];
  logic [7:0] sb_exp;

  always #5 clk = ~clk;

  fifo_rr_scheduler #(
    .NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req(req), .req_data(req_data), .gnt(gnt),
    .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .level(level),
    .fifo_rst(fifo_rst), .fifo_wr(fifo_wr),
    .fifo_rd(fifo_rd), .fifo_din(fifo_din),
    .fifo_dout(fifo_dout), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty)
  );

  // Behavioural FIFO: sync reset, registered dout, write wins.
  logic [7:0] mem [DEPTH];
  logic [3:0] wp, rp;
  logic [4:0] cnt;
  logic [7:0] dout_q;

  always_ff @(posedge clk) begin
    if (fifo_rst) begin
      wp <= '0; rp <= '0; cnt <= '0; dout_q <= '0;
    end else if (fifo_wr && !fifo_full) begin
      mem[wp] <= fifo_din;
      wp <= wp + 1'b1;
      cnt <= cnt + 1'b1;
    end else if (fifo_rd && !fifo_empty) begin
      dout_q <= mem[rp];
      rp <= rp + 1'b1;
      cnt <= cnt - 1'b1;
    end
  end

  assign fifo_dout  = dout_q;
  assign fifo_full  = (cnt == 5'(DEPTH-1));
  assign fifo_empty = (cnt == 5'd0);

  always @(negedge clk) begin
    if (rst_n && !fifo_rst && out_valid && out_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL sb_underflow got %h want no word",
                 out_data);
      end else begin
        sb_exp = sb.pop_front();
        if (out_data !== sb_exp)
          $display("FAIL sb_data got %h want %h",
                   out_data, sb_exp);
        else n_pass++;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    req_data = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    sb.delete();
    @(posedge clk); #1;
  endtask

  task automatic wait_drained(output logic ok);
    ok = 1'b0;
    req = '0;
    out_ready = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (!out_valid && level == 4'd0 && fifo_empty) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = '1;
    req_data = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (fifo_rst !== 1'b1)
      $display("FAIL rst_fiforst got %b want 1", fifo_rst);
    else n_pass++;
    n_checks++;
    if (gnt !== 4'b0000)
      $display("FAIL rst_gnt got %b want 0000", gnt);
    else n_pass++;
    n_checks++;
    if (out_valid !== 1'b0)
      $display("FAIL rst_valid got %b want 0", out_valid);
    else n_pass++;
    n_checks++;
    if (level !== 4'd0)
      $display("FAIL rst_level got %0d want 0", level);
    else n_pass++;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({fifo_rst, gnt} !== 5'b10000)
      $display("FAIL rel_hold got %b want 10000",
               {fifo_rst, gnt});
    else n_pass++;
    @(posedge clk); #1 req = '0;
    @(negedge clk);
    n_checks++;
    if ({fifo_rst, fifo_empty} !== 2'b01)
      $display("FAIL rel_clear got %b want 01",
               {fifo_rst, fifo_empty});
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_rr();
    logic [3:0] pc [NREQ];
    logic [3:0] exp_g;
    int w;
    for (int i = 0; i < NREQ; i++) pc[i] = 4'd0;
    out_ready = 1'b0;
    req = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < NREQ; i++)
        req_data[i*WIDTH +: WIDTH] = {4'(i), pc[i]};
      if (c == 0) w = 0;
      else if (c >= 2 && c <= 16) w = (c - 1) % NREQ;
      else w = -1;
      exp_g = (w < 0) ? 4'b0000 : 4'(1 << w);
      @(negedge clk);
      n_checks++;
      if (gnt !== exp_g)
        $display("FAIL rr_gnt c%0d got %b want %b",
                 c, gnt, exp_g);
      else n_pass++;
      if (c == 1) begin
        n_checks++;
        if (fifo_rd !== 1'b1)
          $display("FAIL rr_rdslot got %b want 1", fifo_rd);
        else n_pass++;
      end
      if (c >= 17) begin
        n_checks++;
        if (level !== 4'd15)
          $display("FAIL rr_level c%0d got %0d want 15",
                   c, level);
        else n_pass++;
      end
      if (w >= 0) sb.push_back({4'(w), pc[w]});
      @(posedge clk); #1;
      if (w >= 0) pc[w] = pc[w] + 4'd1;
    end
  endtask

  task automatic test_full();
    logic ok;
    req = 4'b0010;
    req_data = '0;
    req_data[1*WIDTH +: WIDTH] = 8'h5A;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({gnt, fifo_wr} !== 5'b00000)
        $display("FAIL full_block c%0d got %b want 00000",
                 c, {gnt, fifo_wr});
      else n_pass++;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({gnt, fifo_rd} !== 5'b00001)
      $display("FAIL full_read got %b want 00001",
               {gnt, fifo_rd});
    else n_pass++;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({gnt, fifo_wr, level} !== {4'b0010, 1'b1, 4'd14})
      $display("FAIL full_gnt1 got %b want 0010_1_1110",
               {gnt, fifo_wr, level});
    else n_pass++;
    sb.push_back(8'h5A);
    @(posedge clk); #1 req = '0;
    @(negedge clk);
    n_checks++;
    if (level !== 4'd15)
      $display("FAIL full_level got %0d want 15", level);
    else n_pass++;
    @(posedge clk); #1;
    wait_drained(ok);
    n_checks++;
    if ({ok, sb.size() == 0} !== 2'b11)
      $display("FAIL full_drain got %b want 11",
               {ok, sb.size() == 0});
    else n_pass++;
  endtask

  task automatic test_interleave();
    logic ok;
    logic ew;
    logic [7:0] d;
    do_reset();
    out_ready = 1'b1;
    req = 4'b0001;
    d = 8'hA5;
    for (int c = 0; c < 12; c++) begin
      req_data[0 +: WIDTH] = d;
      ew = (c % 2 == 0);
      @(negedge clk);
      n_checks++;
      if ({fifo_wr, fifo_rd, gnt} !==
          {ew, !ew, 3'b000, ew})
        $display("FAIL il_slot c%0d got %b want %b", c,
                 {fifo_wr, fifo_rd, gnt},
                 {ew, !ew, 3'b000, ew});
      else n_pass++;
      if (ew) sb.push_back(d);
      @(posedge clk); #1;
      if (ew) d = d + 8'd1;
    end
    wait_drained(ok);
    n_checks++;
    if ({ok, sb.size() == 0} !== 2'b11)
      $display("FAIL il_drain got %b want 11",
               {ok, sb.size() == 0});
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [7:0] wd [4];
    logic [3:0] eg [4];
    wd[0] = 8'h11; wd[1] = 8'h22;
    wd[2] = 8'h22; wd[3] = 8'h33;
    eg[0] = 4'b0100; eg[1] = 4'b0000;
    eg[2] = 4'b0100; eg[3] = 4'b0100;
    do_reset();
    out_ready = 1'b0;
    req = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      req_data[2*WIDTH +: WIDTH] = wd[c];
      @(negedge clk);
      n_checks++;
      if (gnt !== eg[c])
        $display("FAIL bp_gnt c%0d got %b want %b",
                 c, gnt, eg[c]);
      else n_pass++;
      if (eg[c] != 4'b0000) sb.push_back(wd[c]);
      @(posedge clk); #1;
    end
    req = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({out_valid, out_data} !== {1'b1, 8'h11})
        $display("FAIL bp_hold c%0d got %b_%h want 1_11",
                 c, out_valid, out_data);
      else n_pass++;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int c = 1; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if ({out_valid, out_data} !== {1'b1, wd[c == 1 ? 0 : c]})
        $display("FAIL bp_b2b c%0d got %b_%h want 1_%h",
                 c, out_valid, out_data, wd[c == 1 ? 0 : c]);
      else n_pass++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_checks++;
    if ({out_valid, sb.size() == 0} !== 2'b01)
      $display("FAIL bp_end got %b want 01",
               {out_valid, sb.size() == 0});
    else n_pass++;
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  task automatic test_midreset();
    logic ok;
    logic [7:0] d;
    do_reset();
    out_ready = 1'b0;
    req = 4'b1000;
    d = 8'hC0;
    for (int c = 0; c < 7; c++) begin
      req_data[3*WIDTH +: WIDTH] = d;
      @(negedge clk);
      n_checks++;
      if (gnt !== (c == 1 ? 4'b0000 : 4'b1000))
        $display("FAIL mr_gnt c%0d got %b", c, gnt);
      else n_pass++;
      if (c != 1) sb.push_back(d);
      @(posedge clk); #1;
      if (c != 1) d = d + 8'd1;
    end
    req = '0;
    @(negedge clk);
    n_checks++;
    if ({out_valid, level} !== {1'b1, 4'd5})
      $display("FAIL mr_pre got %b_%0d want 1_5",
               out_valid, level);
    else n_pass++;
    #1 rst_n = 1'b0;
    req = 4'b1111;
    req_data = '0;
    req_data[0 +: WIDTH] = 8'h77;
    sb.delete();
    #1;
    n_checks++;
    if ({out_valid, level, fifo_rst, gnt} !==
        {1'b0, 4'd0, 1'b1, 4'b0000})
      $display("FAIL mr_async got %b want 0_0000_1_0000",
               {out_valid, level, fifo_rst, gnt});
    else n_pass++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if ({fifo_empty, level, out_valid, gnt} !==
        {1'b1, 4'd0, 1'b0, 4'b0001})
      $display("FAIL mr_after got %b want 1_0000_0_0001",
               {fifo_empty, level, out_valid, gnt});
    else n_pass++;
    sb.push_back(8'h77);
    @(posedge clk); #1 req = '0;
    wait_drained(ok);
    n_checks++;
    if ({ok, sb.size() == 0} !== 2'b11)
      $display("FAIL mr_drain got %b want 11",
               {ok, sb.size() == 0});
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    req = '0;
    req_data = '0;
    out_ready = 1'b0;
    test_reset();
    test_rr();
    test_full();
    test_interleave();
    test_backpressure();
    test_midreset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
